// File: rtl/store_word_writer.sv
`default_nettype none
// ============================================================================
// Module   : store_word_writer
// Purpose  : Serialises a byte, halfword or word store into big-endian
//            one-byte writes on a byte-addressed memory port. The most
//            significant stored byte lands at the base address.
// Revision : 1.0 - initial release
// ============================================================================
module store_word_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Store size encodings.
  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;
  localparam logic [1:0] C_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q;
  // Remaining store bytes, left-justified: the next byte to write is
  // always in [31:24], so big-endian ordering reduces to a left shift.
  logic [31:0]       shift_q;
  // Number of bytes still to write after the one currently on the port.
  logic [1:0]        left_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Left-justified request data and byte count derived from the size.
  logic [31:0]       wdata_just_d;
  logic [1:0]        left_d;
  logic              size_ok_d;

  // Decode the request size into left-justified data and a byte count.
  always_comb begin
    wdata_just_d = 32'h0;
    left_d       = 2'd0;
    size_ok_d    = 1'b1;
    case (size_i)
      C_SIZE_BYTE: begin
        wdata_just_d = {wdata_i[7:0], 24'h0};
        left_d       = 2'd0;
      end
      C_SIZE_HALF: begin
        wdata_just_d = {wdata_i[15:0], 16'h0};
        left_d       = 2'd1;
      end
      C_SIZE_WORD: begin
        wdata_just_d = wdata_i;
        left_d       = 2'd3;
      end
      default: begin
        size_ok_d    = 1'b0;
      end
    endcase
  end

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= 32'h0;
      left_q      <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_we_q <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (size_ok_d) begin
              // First byte goes out in the cycle right after acceptance.
              state_q     <= S_WRITE;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_i;
              mem_wdata_q <= wdata_just_d[31:24];
              shift_q     <= {wdata_just_d[23:0], 8'h0};
              left_q      <= left_d;
            end else begin
              // Illegal size: report straight away, never touch memory.
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (left_q == 2'd0) begin
            // Last byte has been presented; address/data hold their values.
            state_q  <= S_FINISH;
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
          end else begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= shift_q[31:24];
            shift_q     <= {shift_q[23:0], 8'h0};
            left_q      <= left_q - 2'd1;
          end
        end
        S_FINISH: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_store_word_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_word_writer
// Purpose  : Scoreboard bench for store_word_writer. Expected byte writes,
//            done pulses and busy windows are queued when a request is
//            driven and compared cycle by cycle against the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_word_writer;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  size_i;
  logic [7:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  store_word_writer #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .size_i      (size_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int   c;
    logic e;
  } dn_t;

  wr_t        r_wq[$];
  dn_t        r_dq[$];
  bit         r_busy_map[int];
  logic [7:0] r_mem [256];
  int         r_cyc;
  int         r_total;
  int         r_bad;
  bit         r_mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) r_cyc <= r_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_total++;
    if (got !== exp) begin
      r_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, r_cyc);
    end
  endtask

  // Queue the writes, done pulse and busy window of one request whose
  // start is sampled at the edge that makes r_cyc == e0.
  task automatic push_req(input int e0, input logic [7:0] a, input logic [31:0] d,
                          input logic [1:0] sz);
    int    n;
    wr_t   w;
    dn_t   dn;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    for (int k = 0; k < n; k++) begin
      w.c = e0 + k;
      w.a = a + 8'(k);
      w.d = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
      r_wq.push_back(w);
    end
    dn.c = e0 + n;
    dn.e = (sz == 2'd3);
    r_dq.push_back(dn);
    for (int c = e0; c <= e0 + n; c++) r_busy_map[c] = 1'b1;
  endtask

  // Single request: start for one cycle, then wait out the occupancy.
  task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    @(negedge clk);
    start_i = 1'b1;
    addr_i  = a;
    wdata_i = d;
    size_i  = sz;
    push_req(r_cyc + 1, a, d, sz);
    @(negedge clk);
    start_i = 1'b0;
    addr_i  = 8'h00;
    wdata_i = 32'h0;
    repeat (n + 2) @(negedge clk);
  endtask

  function automatic logic [31:0] fetch(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {r_mem[a], r_mem[a1], r_mem[a2], r_mem[a3]};
  endfunction

  // Cycle monitor: compare the port against the scoreboard queues.
  always @(posedge clk) begin
    #1;
    if (r_mon_en) begin
      bit exp_we;
      bit exp_done;
      while (r_wq.size() > 0 && r_wq[0].c < r_cyc) begin
        chk("we_missed_cycle", 32'(r_cyc), 32'(r_wq[0].c));
        void'(r_wq.pop_front());
      end
      exp_we = (r_wq.size() > 0) && (r_wq[0].c == r_cyc);
      chk("mem_we", {31'h0, mem_we_o}, {31'h0, exp_we});
      if (exp_we) begin
        wr_t w;
        w = r_wq.pop_front();
        if (mem_we_o) begin
          chk("mem_addr", {24'h0, mem_addr_o}, {24'h0, w.a});
          chk("mem_wdata", {24'h0, mem_wdata_o}, {24'h0, w.d});
        end
      end
      if (mem_we_o) r_mem[mem_addr_o] = mem_wdata_o;

      while (r_dq.size() > 0 && r_dq[0].c < r_cyc) begin
        chk("done_missed_cycle", 32'(r_cyc), 32'(r_dq[0].c));
        void'(r_dq.pop_front());
      end
      exp_done = (r_dq.size() > 0) && (r_dq[0].c == r_cyc);
      chk("done", {31'h0, done_o}, {31'h0, exp_done});
      if (exp_done) begin
        dn_t dn;
        dn = r_dq.pop_front();
        chk("err", {31'h0, err_o}, {31'h0, dn.e});
      end else begin
        chk("err_idle", {31'h0, err_o}, 32'h0);
      end
      chk("busy", {31'h0, busy_o}, {31'h0, r_busy_map.exists(r_cyc)});
    end
  end

  initial begin
    int e0;
    r_cyc    = 0;
    r_total  = 0;
    r_bad    = 0;
    r_mon_en = 1'b0;
    rst      = 1'b1;
    start_i  = 1'b0;
    addr_i   = 8'h00;
    wdata_i  = 32'h0;
    size_i   = 2'd0;
    for (int i = 0; i < 256; i++) r_mem[i] = 8'h00;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_addr", {24'h0, mem_addr_o}, 32'h0);
    chk("rst_wdata", {24'h0, mem_wdata_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    r_mon_en = 1'b1;
    @(negedge clk);

    // Word, halfword, byte, wrapped word, illegal size.
    issue(8'h10, 32'hDEADBEEF, 2'd2);
    issue(8'h20, 32'h1234ABCD, 2'd1);
    issue(8'h30, 32'h000000EE, 2'd0);
    issue(8'hFE, 32'h01020304, 2'd2);
    issue(8'h80, 32'h99999999, 2'd3);

    // Start held high across two words: second accepted at E(N+2) only.
    @(negedge clk);
    start_i = 1'b1;
    addr_i  = 8'h50;
    wdata_i = 32'h11223344;
    size_i  = 2'd2;
    e0      = r_cyc + 1;
    push_req(e0, 8'h50, 32'h11223344, 2'd2);
    push_req(e0 + 6, 8'h60, 32'h55667788, 2'd2);
    @(negedge clk);
    addr_i  = 8'h60;
    wdata_i = 32'h55667788;
    repeat (6) @(negedge clk);
    start_i = 1'b0;
    addr_i  = 8'h00;
    wdata_i = 32'h0;
    repeat (8) @(negedge clk);

    // Asynchronous reset during byte 2 of a word store.
    @(negedge clk);
    start_i = 1'b1;
    addr_i  = 8'h70;
    wdata_i = 32'hA1B2C3D4;
    size_i  = 2'd2;
    push_req(r_cyc + 1, 8'h70, 32'hA1B2C3D4, 2'd2);
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_we", {31'h0, mem_we_o}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_done", {31'h0, done_o}, 32'h0);
    chk("arst_addr", {24'h0, mem_addr_o}, 32'h0);
    chk("arst_wdata", {24'h0, mem_wdata_o}, 32'h0);
    r_wq.delete();
    r_dq.delete();
    r_busy_map.delete();
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(8'h40, 32'hCAFEF00D, 2'd2);
    repeat (2) @(negedge clk);

    // Read everything back the way the fetch path would.
    chk("fetch_10", fetch(8'h10), 32'hDEADBEEF);
    chk("fetch_20_half", {16'h0, r_mem[8'h20], r_mem[8'h21]}, 32'h0000ABCD);
    chk("fetch_30_byte", {24'h0, r_mem[8'h30]}, 32'h000000EE);
    chk("fetch_FE_wrap", fetch(8'hFE), 32'h01020304);
    chk("fetch_50", fetch(8'h50), 32'h11223344);
    chk("fetch_60", fetch(8'h60), 32'h55667788);
    chk("fetch_40", fetch(8'h40), 32'hCAFEF00D);
    chk("fetch_80_untouched", fetch(8'h80), 32'h0);
    chk("fetch_70_partial", fetch(8'h70), 32'hA1B2C300);
    chk("wq_drained", 32'(r_wq.size()), 32'h0);
    chk("dq_drained", 32'(r_dq.size()), 32'h0);

    r_mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", r_total, r_bad);
    $finish;
  end

endmodule
`default_nettype wire
